multi_cycle_control: RTL and testbench
======================================

Name: multi_cycle_control

Overview:
Moore-style FSM that sequences the multi-cycle MIPS datapath: one shared memory, one ALU, and IR/A/B/ALUOut/MDR holding registers. It decodes the same instruction subset as the single-cycle decoder: R-type, lw, sw, beq, j, ori, addi, addiu, andi, lui, slti, sltiu, xori. It drives per-state strobes to the PC, IR, register file, memory and ALU muxes. It sits between the instruction register and the datapath and replaces the single-cycle control path.

Parameters:
STATE_W, 4, width of the state register and State debug port.
ALUOP_W, 4, width of ALUOp; encodings come from the shared package.

Ports:
CLK  in  1  rising-edge clock.
Reset  in  1  synchronous, active-high reset.
Opcode  in  6  IR[31:26]; valid from DECODE onward.
Func  in  6  IR[5:0].
Zero  in  1  ALU zero flag; sampled in BRANCH.
MemReady  in  1  memory done; used only with MEM_WAIT_EN.
PCWrite  out  1  unconditional PC load.
PCWriteCond  out  1  PC load when Zero=1.
PCSource  out  2  00=ALU result, 01=ALUOut, 10=jump target.
IorD  out  1  memory address: 0=PC, 1=ALUOut.
MemRead  out  1  memory read strobe.
MemWrite  out  1  memory write strobe.
IRWrite  out  1  instruction register load.
RegDst  out  1  register file write address: 1=rd, 0=rt.
MemToReg  out  1  register file write data: 1=MDR, 0=ALUOut.
RegWrite  out  1  register file write enable.
ALUSrc1  out  2  ALU input A: 00=A, 01=shamt, 10=PC.
ALUSrc2  out  2  ALU input B: 00=B, 01=const 4, 10=ext imm, 11=ext imm<<2.
SignExtend  out  1  1=sign-extend, 0=zero-extend imm.
ALUOp  out  4  ALU operation code; 4'b1111 = decode from Func.
IllegalOp  out  1  one-cycle pulse on an unknown opcode.
State  out  4  current state, for debug.

Behaviour:
- Clock and reset: single clock CLK; synchronous active-high Reset.
- Reset:
  - On a CLK edge with Reset=1, State goes to FETCH(0).
  - While Reset=1, these outputs are forced to 0: PCWrite, PCWriteCond, IRWrite, RegWrite, MemRead, MemWrite, IllegalOp.
  - All other outputs are 0 during reset.
  - Reset mid-instruction aborts it; no partial writeback occurs after the reset edge.
- Outputs: combinational from State (plus Opcode/Func where noted). Outputs not listed for a state are 0.
- State encodings and actions:
  - FETCH(0): MemRead, IRWrite, ALUSrc1=10, ALUSrc2=01, ALUOp=ADD, PCWrite, PCSource=00. Next: DECODE.
  - DECODE(1): ALUSrc1=10, ALUSrc2=11, SignExtend=1, ALUOp=ADD (precomputes branch target into ALUOut). Next by opcode:
    - lw/sw -> MEMADDR
    - R-type -> REXEC
    - beq -> BRANCH
    - j -> JUMP
    - I-type ALU ops -> IEXEC
    - any other opcode -> FETCH, with IllegalOp=1 for this cycle only.
  - MEMADDR(2): ALUSrc1=00, ALUSrc2=10, SignExtend=1, ALUOp=ADD. Next: MEMREAD for lw, MEMWRITE for sw.
  - MEMREAD(3): IorD=1, MemRead. Next: MEMWB.
  - MEMWB(4): RegDst=0, MemToReg=1, RegWrite. Next: FETCH.
  - MEMWRITE(5): IorD=1, MemWrite. Next: FETCH.
  - REXEC(6): ALUSrc1=01 if Func is 000000, 000010 or 000011 (shifts), else 00; ALUSrc2=00; ALUOp=1111. Next: RWB.
  - RWB(7): RegDst=1, MemToReg=0, RegWrite. Next: FETCH.
  - BRANCH(8): ALUSrc1=00, ALUSrc2=00, ALUOp=SUB, PCWriteCond, PCSource=01. Next: FETCH.
  - JUMP(9): PCWrite, PCSource=10. Next: FETCH.
  - IEXEC(10): ALUSrc1=00, ALUSrc2=10. ALUOp and SignExtend by opcode:
    - ori: OR, zero-extend
    - addi: ADD, sign-extend
    - addiu: ADDU, sign-extend
    - andi: AND, zero-extend
    - lui: LUI, don't-care driven 0
    - slti: SLT, sign-extend
    - sltiu: SLTU, sign-extend
    - xori: XOR, zero-extend
    Next: IWB.
  - IWB(11): RegDst=0, MemToReg=0, RegWrite; ALUSrc2, SignExtend and ALUOp held from IEXEC. Next: FETCH.
- Unused encodings 12-15 go to FETCH on the next edge.
- Latency in cycles, FETCH to next FETCH: beq=3, j=3, sw=4, R-type=4, I-type=4, lw=5.
- No x outputs in any state.

Optional Feature:
MEM_WAIT_EN
- Defined:
  - FETCH, MEMREAD and MEMWRITE hold the state while MemReady=0, keeping MemRead/MemWrite/IorD asserted.
  - IRWrite and PCWrite assert in FETCH only in the cycle MemReady=1.
  - MEMREAD and MEMWRITE advance only when MemReady=1.
  - Reset during a wait returns to FETCH.
- Undefined: MemReady is ignored; every memory state lasts exactly one cycle.

Decomposition:
- Shared package mips_pkg holds:
  - opcode constants (RTYPE, LW, SW, BEQ, J, ORI, ADDI, ADDIU, ANDI, LUI, SLTI, SLTIU, XORI);
  - ALUOp encodings (AND=0, OR=1, ADD=2, SLL=3, SRL=4, SUB=6, SLT=7, ADDU=8, SUBU=9, XOR=10, SLTU=11, NOR=12, SRA=13, LUI=14, FUNC=15);
  - state encodings 0-11.
- One sub-module, imm_alu_decode: combinational map from Opcode/Func to ALUOp, SignExtend and shift select. Used by IEXEC/IWB and REXEC.

Test Plan:
- Reset held 2 cycles mid-lw (in MEMREAD) -> State=0, all write enables 0; first post-reset cycle shows FETCH strobes.
- lw (Opcode 100011) -> states 0,1,2,3,4,0; RegWrite=1 with MemToReg=1 only in state 4.
- beq with Zero=1, then beq with Zero=0 -> states 0,1,8 both times; PCWriteCond=1 and PCSource=01 in state 8.
- R-type sll (Func 000000), then add (Func 100000) -> ALUSrc1=01, then 00, in REXEC; ALUOp=1111; RWB has RegDst=1.
- ori then addi -> IEXEC ALUOp=1 SignExtend=0, then ALUOp=2 SignExtend=1; Opcode 111111 -> IllegalOp pulses in DECODE, returns to FETCH.
- With MEM_WAIT_EN, MemReady low 3 cycles in FETCH -> State stays 0 for 4 cycles; IRWrite and PCWrite high only in the 4th.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS encodings: opcodes, ALU operation codes, and control FSM states.
// Imported by the multi-cycle control path and its decode helper.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_XORI  = 6'b001110;

    localparam logic [3:0] ALU_AND  = 4'd0;
    localparam logic [3:0] ALU_OR   = 4'd1;
    localparam logic [3:0] ALU_ADD  = 4'd2;
    localparam logic [3:0] ALU_SLL  = 4'd3;
    localparam logic [3:0] ALU_SRL  = 4'd4;
    localparam logic [3:0] ALU_SUB  = 4'd6;
    localparam logic [3:0] ALU_SLT  = 4'd7;
    localparam logic [3:0] ALU_ADDU = 4'd8;
    localparam logic [3:0] ALU_SUBU = 4'd9;
    localparam logic [3:0] ALU_XOR  = 4'd10;
    localparam logic [3:0] ALU_SLTU = 4'd11;
    localparam logic [3:0] ALU_NOR  = 4'd12;
    localparam logic [3:0] ALU_SRA  = 4'd13;
    localparam logic [3:0] ALU_LUI  = 4'd14;
    localparam logic [3:0] ALU_FUNC = 4'd15;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADDR  = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_REXEC    = 4'd6,
        S_RWB      = 4'd7,
        S_BRANCH   = 4'd8,
        S_JUMP     = 4'd9,
        S_IEXEC    = 4'd10,
        S_IWB      = 4'd11
    } state_e;

endpackage

// File: rtl/multi_cycle_control_imm_alu_decode.sv
// Opcode/Func to ALU operation, immediate extension mode and shamt select.
// Purely combinational; shared by the R-type and I-type execute states.
module imm_alu_decode
    import mips_pkg::*;
(
    input  logic [5:0] opcode_i,
    input  logic [5:0] func_i,
    output logic [3:0] alu_op_o,
    output logic       sign_ext_o,
    output logic       shift_sel_o
);

    // I-type operation and extension mode; lui needs no extension
    always_comb begin
        alu_op_o   = ALU_ADD;
        sign_ext_o = 1'b0;
        unique case (opcode_i)
            OP_ORI:   begin alu_op_o = ALU_OR;   sign_ext_o = 1'b0; end
            OP_ADDI:  begin alu_op_o = ALU_ADD;  sign_ext_o = 1'b1; end
            OP_ADDIU: begin alu_op_o = ALU_ADDU; sign_ext_o = 1'b1; end
            OP_ANDI:  begin alu_op_o = ALU_AND;  sign_ext_o = 1'b0; end
            OP_LUI:   begin alu_op_o = ALU_LUI;  sign_ext_o = 1'b0; end
            OP_SLTI:  begin alu_op_o = ALU_SLT;  sign_ext_o = 1'b1; end
            OP_SLTIU: begin alu_op_o = ALU_SLTU; sign_ext_o = 1'b1; end
            OP_XORI:  begin alu_op_o = ALU_XOR;  sign_ext_o = 1'b0; end
            default:  begin alu_op_o = ALU_ADD;  sign_ext_o = 1'b0; end
        endcase
    end

    // Constant shifts (sll/srl/sra) take shamt as ALU input A
    always_comb begin
        shift_sel_o = (func_i == 6'b000000) ||
                      (func_i == 6'b000010) ||
                      (func_i == 6'b000011);
    end

endmodule

// File: rtl/multi_cycle_control.sv
// Moore control FSM for the multi-cycle MIPS datapath.
// Optional MEM_WAIT_EN: memory states stall until MemReady=1.
module multi_cycle_control
    import mips_pkg::*;
#(
    parameter int STATE_W = 4,
    parameter int ALUOP_W = 4
) (
    input  logic               CLK,
    input  logic               Reset,
    input  logic [5:0]         Opcode,
    input  logic [5:0]         Func,
    input  logic               Zero,
    input  logic               MemReady,
    output logic               PCWrite,
    output logic               PCWriteCond,
    output logic [1:0]         PCSource,
    output logic               IorD,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic               RegDst,
    output logic               MemToReg,
    output logic               RegWrite,
    output logic [1:0]         ALUSrc1,
    output logic [1:0]         ALUSrc2,
    output logic               SignExtend,
    output logic [ALUOP_W-1:0] ALUOp,
    output logic               IllegalOp,
    output logic [STATE_W-1:0] State
);

    state_e     state_q;
    state_e     state_d;
    logic [3:0] imm_op;
    logic       imm_sext;
    logic       shift_sel;
    logic [3:0] alu_op;
    logic       mem_rdy;
    logic       unused_in;

    // Zero is consumed by the datapath PC-load gate, not by the FSM
    assign unused_in = Zero ^ MemReady;

`ifdef MEM_WAIT_EN
    assign mem_rdy = MemReady;
`else
    assign mem_rdy = 1'b1;
`endif

    imm_alu_decode u_dec (
        .opcode_i    (Opcode),
        .func_i      (Func),
        .alu_op_o    (imm_op),
        .sign_ext_o  (imm_sext),
        .shift_sel_o (shift_sel)
    );

    // State register with synchronous reset to FETCH
    always_ff @(posedge CLK) begin
        if (Reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    // Next state and per-state strobes; reset forces every output low
    always_comb begin
        state_d     = S_FETCH;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        PCSource    = 2'b00;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        RegDst      = 1'b0;
        MemToReg    = 1'b0;
        RegWrite    = 1'b0;
        ALUSrc1     = 2'b00;
        ALUSrc2     = 2'b00;
        SignExtend  = 1'b0;
        alu_op      = ALU_AND;
        IllegalOp   = 1'b0;
        case (state_q)
            S_FETCH: begin
                MemRead = 1'b1;
                IRWrite = mem_rdy;
                PCWrite = mem_rdy;
                ALUSrc1 = 2'b10;
                ALUSrc2 = 2'b01;
                alu_op  = ALU_ADD;
                state_d = mem_rdy ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                ALUSrc1    = 2'b10;
                ALUSrc2    = 2'b11;
                SignExtend = 1'b1;
                alu_op     = ALU_ADD;
                case (Opcode)
                    OP_LW, OP_SW: state_d = S_MEMADDR;
                    OP_RTYPE:     state_d = S_REXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    OP_ORI, OP_ADDI, OP_ADDIU, OP_ANDI,
                    OP_LUI, OP_SLTI, OP_SLTIU, OP_XORI:
                                  state_d = S_IEXEC;
                    default: begin
                        state_d   = S_FETCH;
                        IllegalOp = 1'b1;
                    end
                endcase
            end
            S_MEMADDR: begin
                ALUSrc2    = 2'b10;
                SignExtend = 1'b1;
                alu_op     = ALU_ADD;
                state_d    = (Opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                IorD    = 1'b1;
                MemRead = 1'b1;
                state_d = mem_rdy ? S_MEMWB : S_MEMREAD;
            end
            S_MEMWB: begin
                MemToReg = 1'b1;
                RegWrite = 1'b1;
            end
            S_MEMWRITE: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
                state_d  = mem_rdy ? S_FETCH : S_MEMWRITE;
            end
            S_REXEC: begin
                ALUSrc1 = shift_sel ? 2'b01 : 2'b00;
                alu_op  = ALU_FUNC;
                state_d = S_RWB;
            end
            S_RWB: begin
                RegDst   = 1'b1;
                RegWrite = 1'b1;
            end
            S_BRANCH: begin
                alu_op      = ALU_SUB;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
            end
            S_JUMP: begin
                PCWrite  = 1'b1;
                PCSource = 2'b10;
            end
            S_IEXEC: begin
                ALUSrc2    = 2'b10;
                SignExtend = imm_sext;
                alu_op     = imm_op;
                state_d    = S_IWB;
            end
            S_IWB: begin
                RegWrite   = 1'b1;
                ALUSrc2    = 2'b10;
                SignExtend = imm_sext;
                alu_op     = imm_op;
            end
            default: state_d = S_FETCH;
        endcase
        ALUOp = ALUOP_W'(alu_op);
        State = STATE_W'(state_q);
        if (Reset) begin
            PCWrite     = 1'b0;
            PCWriteCond = 1'b0;
            PCSource    = 2'b00;
            IorD        = 1'b0;
            MemRead     = 1'b0;
            MemWrite    = 1'b0;
            IRWrite     = 1'b0;
            RegDst      = 1'b0;
            MemToReg    = 1'b0;
            RegWrite    = 1'b0;
            ALUSrc1     = 2'b00;
            ALUSrc2     = 2'b00;
            SignExtend  = 1'b0;
            ALUOp       = '0;
            IllegalOp   = 1'b0;
            State       = '0;
        end
    end

endmodule

// File: tb/tb_multi_cycle_control.sv
// Scoreboard bench for multi_cycle_control: per-cycle expected strobes
// derived from instruction class; build with +define+MEM_WAIT_EN for stalls.
module tb_multi_cycle_control;

    typedef struct packed {
        logic [3:0] st;
        logic       pcw;
        logic       pcwc;
        logic [1:0] pcsrc;
        logic       iord;
        logic       mrd;
        logic       mwr;
        logic       irw;
        logic       rdst;
        logic       m2r;
        logic       rw;
        logic [1:0] s1;
        logic [1:0] s2;
        logic       sx;
        logic [3:0] aop;
        logic       ill;
    } exp_t;

    logic       CLK = 1'b0;
    logic       Reset = 1'b1;
    logic [5:0] Opcode = 6'd0;
    logic [5:0] Func = 6'd0;
    logic       Zero = 1'b0;
    logic       MemReady = 1'b1;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic       RegDst, MemToReg, RegWrite, SignExtend, IllegalOp;
    logic [1:0] PCSource, ALUSrc1, ALUSrc2;
    logic [3:0] ALUOp, State;

    exp_t  sb[$];
    string nq[$];
    int    errors = 0;
    int    checks = 0;

    multi_cycle_control #(.STATE_W(4), .ALUOP_W(4)) dut (
        .CLK(CLK), .Reset(Reset), .Opcode(Opcode), .Func(Func),
        .Zero(Zero), .MemReady(MemReady),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .PCSource(PCSource),
        .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
        .IRWrite(IRWrite), .RegDst(RegDst), .MemToReg(MemToReg),
        .RegWrite(RegWrite), .ALUSrc1(ALUSrc1), .ALUSrc2(ALUSrc2),
        .SignExtend(SignExtend), .ALUOp(ALUOp), .IllegalOp(IllegalOp),
        .State(State)
    );

    always #5 CLK = ~CLK;

    // Monitor: compare whatever the DUT presents against the queue head
    always @(negedge CLK) begin
        exp_t  a, e;
        string n;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            n = nq.pop_front();
            a = '{State, PCWrite, PCWriteCond, PCSource, IorD, MemRead,
                  MemWrite, IRWrite, RegDst, MemToReg, RegWrite, ALUSrc1,
                  ALUSrc2, SignExtend, ALUOp, IllegalOp};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL %s: got %h expected %h", n, a, e);
            end
        end
    end

    function automatic bit is_itype(logic [5:0] op);
        return op inside {6'b001101, 6'b001000, 6'b001001, 6'b001100,
                          6'b001111, 6'b001010, 6'b001011, 6'b001110};
    endfunction

    function automatic bit is_legal(logic [5:0] op);
        return is_itype(op) ||
               op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010};
    endfunction

    // Behavioural expectation for one cycle in a named phase
    function automatic exp_t model(int st, logic [5:0] op, logic [5:0] fn,
                                   bit rdy);
        exp_t e = '0;
        bit go = 1'b1;
`ifdef MEM_WAIT_EN
        go = rdy;
`endif
        e.st = 4'(st);
        case (st)
            0: begin
                e.mrd = 1; e.irw = go; e.pcw = go;
                e.s1 = 2'b10; e.s2 = 2'b01; e.aop = 4'd2;
            end
            1: begin
                e.s1 = 2'b10; e.s2 = 2'b11; e.sx = 1; e.aop = 4'd2;
                e.ill = !is_legal(op);
            end
            2: begin e.s2 = 2'b10; e.sx = 1; e.aop = 4'd2; end
            3: begin e.iord = 1; e.mrd = 1; end
            4: begin e.m2r = 1; e.rw = 1; end
            5: begin e.iord = 1; e.mwr = 1; end
            6: begin
                e.s1 = (fn == 0 || fn == 2 || fn == 3) ? 2'b01 : 2'b00;
                e.aop = 4'd15;
            end
            7: begin e.rdst = 1; e.rw = 1; end
            8: begin e.aop = 4'd6; e.pcwc = 1; e.pcsrc = 2'b01; end
            9: begin e.pcw = 1; e.pcsrc = 2'b10; end
            10, 11: begin
                e.s2 = 2'b10;
                e.rw = (st == 11);
                case (op)
                    6'b001101: begin e.aop = 4'd1;  e.sx = 0; end
                    6'b001000: begin e.aop = 4'd2;  e.sx = 1; end
                    6'b001001: begin e.aop = 4'd8;  e.sx = 1; end
                    6'b001100: begin e.aop = 4'd0;  e.sx = 0; end
                    6'b001111: begin e.aop = 4'd14; e.sx = 0; end
                    6'b001010: begin e.aop = 4'd7;  e.sx = 1; end
                    6'b001011: begin e.aop = 4'd11; e.sx = 1; end
                    default:   begin e.aop = 4'd10; e.sx = 0; end
                endcase
            end
            default: e = '0;
        endcase
        return e;
    endfunction

    task automatic cyc(int st, logic [5:0] op, logic [5:0] fn, bit z,
                       bit rdy, string n);
        @(posedge CLK);
        #1;
        Reset = 0; Opcode = op; Func = fn; Zero = z; MemReady = rdy;
        sb.push_back(model(st, op, fn, rdy));
        nq.push_back(n);
    endtask

    task automatic rst_cyc();
        @(posedge CLK);
        #1;
        Reset = 1; MemReady = 1'($urandom);
        sb.push_back('0);
        nq.push_back("reset");
    endtask

    // Memory phase: random stalls when waits are enabled, else one cycle
    task automatic mem_step(int st, logic [5:0] op, logic [5:0] fn, bit z,
                            int waits, string n);
`ifdef MEM_WAIT_EN
        int w = (waits < 0) ? int'($urandom_range(0, 3)) : waits;
        repeat (w) cyc(st, op, fn, z, 1'b0, {n, "_wait"});
        cyc(st, op, fn, z, 1'b1, n);
`else
        cyc(st, op, fn, z, 1'($urandom), n);
`endif
    endtask

    // State path chosen from the instruction class and its latency
    task automatic run_instr(logic [5:0] op, logic [5:0] fn, bit z,
                             int nsteps, int fwait, string n);
        int seq[$];
        seq = {0, 1};
        if (op == 6'b100011)       seq = {seq, 2, 3, 4};
        else if (op == 6'b101011)  seq = {seq, 2, 5};
        else if (op == 6'b000000)  seq = {seq, 6, 7};
        else if (op == 6'b000100)  seq = {seq, 8};
        else if (op == 6'b000010)  seq = {seq, 9};
        else if (is_itype(op))     seq = {seq, 10, 11};
        foreach (seq[i]) begin
            if (i >= nsteps) break;
            if (seq[i] == 0 || seq[i] == 3 || seq[i] == 5)
                mem_step(seq[i], op, fn, z, (seq[i] == 0) ? fwait : -1,
                         $sformatf("%s_s%0d", n, seq[i]));
            else
                cyc(seq[i], op, fn, z, 1'($urandom),
                    $sformatf("%s_s%0d", n, seq[i]));
        end
    endtask

    initial begin
        logic [5:0] itab[8];
        logic [5:0] ftab[7];
        logic [5:0] op, fn;
        int t;
        itab = '{6'b001101, 6'b001000, 6'b001001, 6'b001100,
                 6'b001111, 6'b001010, 6'b001011, 6'b001110};
        ftab = '{6'h00, 6'h02, 6'h03, 6'h20, 6'h22, 6'h24, 6'h2a};
        @(posedge CLK);
        rst_cyc();
        run_instr(6'b100011, 6'h00, 0, 3, 0, "lw_pre");
        rst_cyc();
        rst_cyc();
        run_instr(6'b100011, 6'h11, 0, 99, 0, "lw");
        run_instr(6'b000100, 6'h00, 1, 99, -1, "beq_z1");
        run_instr(6'b000100, 6'h00, 0, 99, -1, "beq_z0");
        run_instr(6'b000000, 6'h00, 0, 99, -1, "sll");
        run_instr(6'b000000, 6'h20, 0, 99, -1, "add");
        run_instr(6'b001101, 6'h00, 0, 99, -1, "ori");
        run_instr(6'b001000, 6'h00, 0, 99, -1, "addi");
        run_instr(6'b111111, 6'h00, 0, 99, -1, "illegal");
        run_instr(6'b101011, 6'h00, 0, 99, 3, "sw_fwait3");
        run_instr(6'b000010, 6'h00, 0, 99, -1, "j");
        for (int k = 0; k < 300; k++) begin
            case ($urandom_range(0, 7))
                0: op = 6'b100011;
                1: op = 6'b101011;
                2: op = 6'b000100;
                3: op = 6'b000010;
                4, 5: op = 6'b000000;
                6: op = itab[$urandom_range(0, 7)];
                default: begin
                    op = 6'($urandom);
                    while (is_legal(op)) op = 6'($urandom);
                end
            endcase
            fn = ($urandom_range(0, 1) == 1) ? ftab[$urandom_range(0, 6)]
                                             : 6'($urandom);
            if ($urandom_range(0, 19) == 0) begin
                run_instr(op, fn, 1'($urandom),
                          int'($urandom_range(1, 4)), -1, "rnd_cut");
                rst_cyc();
            end else begin
                run_instr(op, fn, 1'($urandom), 99, -1, "rnd");
            end
        end
        t = 0;
        while (sb.size() > 0 && t < 10) begin
            @(posedge CLK);
            t++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
